// File: rtl/mips32_pkg.sv
// mips32_pkg: arbiter FSM state type and data-memory geometry shared with the MIPS32 core
package mips32_pkg;
  typedef enum logic [1:0] {IDLE, CORE_LAST, DBG_LAST, DBG_LOCKED} arb_state_t;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
endpackage

// File: rtl/mips32_mem_arb.sv
// mips32_mem_arb: core/debug arbiter for a single-port data memory with a debug lock mode
// Define MIPS32_MEM_ARB_RR_EN for round-robin collision resolution (default: core first)
module mips32_mem_arb
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  arb_state_t state, state_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic locked, force_c, c_pri;
  assign locked  = state == DBG_LOCKED;
  assign force_c = locked && lock_cnt == CNT_MAX && c_req;
`ifdef MIPS32_MEM_ARB_RR_EN
  logic ptr;
  assign c_pri = ~ptr;
  always_ff @(posedge clk_1 or negedge rst)
    if (!rst) ptr <= 1'b0;
    else if (c_gnt || d_gnt) ptr <= c_gnt;
`else
  assign c_pri = 1'b1;
`endif
  // No grants while reset is held, so nothing reaches memory during reset
  assign c_gnt = rst && (locked ? force_c : c_req && (c_pri || !d_req));
  assign d_gnt = rst && d_req && !(locked ? force_c : c_gnt);
  assign mem_en     = c_gnt || d_gnt;
  assign mem_we     = c_gnt ? c_we : d_gnt && d_we;
  assign mem_addr   = c_gnt ? c_addr : d_addr;
  assign mem_wdata  = c_gnt ? c_wdata : d_wdata;
  assign c_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign core_stall = c_req && !c_gnt;
  always_comb begin
    state_n = locked ? (d_lock ? DBG_LOCKED : IDLE)
            : c_gnt  ? CORE_LAST
            : !d_gnt ? state
            : d_lock ? DBG_LOCKED : DBG_LAST;
    cnt_n   = (state_n != DBG_LOCKED || c_gnt) ? '0
            : (d_gnt && lock_cnt != CNT_MAX) ? lock_cnt + 1'b1 : lock_cnt;
  end
  always_ff @(posedge clk_1 or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= cnt_n;
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
    end
endmodule

// File: tb/tb_mips32_mem_arb.sv
// tb_mips32_mem_arb: directed and random stimulus against a grant-rule reference model
module tb_mips32_mem_arb;
  localparam int AW = 9, DW = 32, LM = 4;
`ifdef MIPS32_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk_1 = 1'b0, rst = 1'b0;
  logic c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] c_addr = '0, d_addr = '0, mem_addr;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0, c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, mem_en, mem_we, core_stall;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] shadow [2**AW];
  int n_vec = 0, n_bad = 0;
  bit m_locked = 0, m_dpri = 0, m_crv = 0, m_drv = 0, ec = 0, ed = 0;
  int m_cnt = 0;
  logic [DW-1:0] m_crd, m_drd;

  always #5 clk_1 = ~clk_1;

  mips32_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk_1(clk_1), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_stall(core_stall)
  );

  always @(posedge clk_1)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are set just after a rising edge; outputs checked on the falling edge
  task automatic step(input bit rst_mid = 1'b0);
    bit we;
    @(negedge clk_1);
    if (!rst) begin ec = 0; ed = 0; end
    else if (m_locked) begin ec = c_req && m_cnt >= LM; ed = d_req && !ec; end
    else begin ec = c_req && (!d_req || !RR || !m_dpri); ed = d_req && !ec; end
    we = ec ? c_we : d_we;
    chk("c_gnt", DW'(c_gnt), DW'(ec));
    chk("d_gnt", DW'(d_gnt), DW'(ed));
    chk("core_stall", DW'(core_stall), DW'(c_req && !ec));
    chk("mem_en", DW'(mem_en), DW'(ec || ed));
    chk("mem_we", DW'(mem_we), DW'((ec || ed) && we));
    if (ec || ed) chk("mem_addr", DW'(mem_addr), DW'(ec ? c_addr : d_addr));
    if ((ec || ed) && we) chk("mem_wdata", mem_wdata, ec ? c_wdata : d_wdata);
    chk("c_rvalid", DW'(c_rvalid), DW'(m_crv));
    chk("d_rvalid", DW'(d_rvalid), DW'(m_drv));
    if (m_crv) chk("c_rdata", c_rdata, m_crd);
    if (m_drv) chk("d_rdata", d_rdata, m_drd);
    m_crv = ec && !c_we;
    m_drv = ed && !d_we;
    if (ec) begin if (c_we) shadow[c_addr] = c_wdata; else m_crd = shadow[c_addr]; end
    if (ed) begin if (d_we) shadow[d_addr] = d_wdata; else m_drd = shadow[d_addr]; end
    if (ec || ed) m_dpri = ec;
    if (m_locked) begin
      if (!d_lock) begin m_locked = 0; m_cnt = 0; end
      else if (ec) m_cnt = 0;
      else if (ed && m_cnt < LM) m_cnt++;
    end else if (ed && d_lock) begin m_locked = 1; m_cnt = 1; end
    if (rst_mid || !rst) begin
      rst = 1'b0; m_locked = 0; m_cnt = 0; m_dpri = 0; m_crv = 0; m_drv = 0;
    end
    @(posedge clk_1); #1;
  endtask

  initial begin
    c_req = 1; d_req = 1;
    repeat (2) step();
    rst = 1'b1;
    // Collision: core read of 5 against debug write of 9
    c_req = 1; c_we = 0; c_addr = 5; d_req = 1; d_we = 1; d_addr = 9; d_wdata = 32'hdead_beef;
    step();
    c_req = 0;
    step();
    d_req = 0;
    step();
    // Back-to-back collisions
    c_req = 1; d_req = 1; d_we = 0;
    repeat (4) step();
    c_req = 0; d_req = 0;
    step();
    // Lock entry, then core held to force the periodic core slot
    d_req = 1; d_lock = 1; d_addr = 9;
    step();
    c_req = 1; c_addr = 7;
    repeat (10) step();
    // Saturation with the core idle, then the core returns
    c_req = 0;
    repeat (6) step();
    c_req = 1;
    repeat (2) step();
    // Unlock: core must win the very next cycle
    d_lock = 0;
    repeat (2) step();
    c_req = 0; d_req = 0;
    step();
    // Reset asserted halfway through a read-grant cycle
    c_req = 1; c_we = 0; c_addr = 5;
    step(1'b1);
    step();
    rst = 1'b1; c_req = 0;
    step();
    // Debug request dropped after losing one collision
    c_req = 1; d_req = 1; d_we = 1; d_addr = 3;
    step();
    c_req = 0; d_req = 0;
    repeat (2) step();
    for (int k = 0; k < 3000; k++) begin
      if (c_req && !ec) begin
        if ($urandom_range(0, 7) == 0) c_req = 0;
      end else begin
        c_req = 1'($urandom_range(0, 1)); c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 31)); c_wdata = $urandom;
      end
      if (d_req && !ed) begin
        if ($urandom_range(0, 7) == 0) d_req = 0;
      end else begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 31)); d_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) d_lock = ~d_lock;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
